// File: rtl/hex_display_mux_if.sv
// Bundles the value/control inputs and the segment/anode outputs of hex_display_mux.
// Latency: none (wiring only). Backpressure: none, all signals are level/pulse.
// Master is the datapath side, slave is the display driver.
interface hex_display_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   blank_mask;
    logic [0:6]          display;
    logic [DIGITS-1:0]   digit_en;
    logic                frame_done;

    modport master (
        output value, load, blank_mask,
        input  display, digit_en, frame_done
    );

    modport slave (
        input  value, load, blank_mask,
        output display, digit_en, frame_done
    );
endinterface

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode seven-segment driver; optional LEADING_ZERO_SUPPRESS_EN.
// Latency: outputs registered, one cycle behind scan state; loads visible 2..DIGITS*REFRESH_DIV+1 cycles.
// Backpressure: none; loads are shadowed and applied only at frame wrap, last load wins.
module hex_display_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clock,
    input  logic              resetn,
    hex_display_mux_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic                pend_v_q, pend_v_d;
    logic                wrap_q;
    logic [0:6]          display_q, display_d;
    logic [DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                frame_done_q;

    logic                term, wrap;
    logic [3:0]          nib;
    logic [0:6]          seg;
    logic [DIGITS-1:0]   lz_dark;
    logic                dark;

    always_comb begin
        term      = (cnt_q == LAST_CNT);
        wrap      = term && (idx_q == LAST_IDX);
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        active_d  = active_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        if (term) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        // A load landing on the wrap cycle goes straight to the active copy.
        if (wrap && bus.load) begin
            active_d = bus.value;
            pend_v_d = 1'b0;
        end else begin
            if (wrap && pend_v_q) begin
                active_d = pending_q;
                pend_v_d = 1'b0;
            end
            if (bus.load) begin
                pending_d = bus.value;
                pend_v_d  = 1'b1;
            end
        end
    end

    always_comb begin
        lz_dark = '0;
`ifdef LEADING_ZERO_SUPPRESS_EN
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_dark[k] = (active_q[4*k +: 4] == 4'h0) && ((k == DIGITS - 1) || lz_dark[k+1]);
        end
`endif
    end

    always_comb begin
        nib = active_q[{idx_q, 2'b00} +: 4];
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        dark       = bus.blank_mask[idx_q] | lz_dark[idx_q];
        display_d  = dark ? 7'b1111111 : seg;
        digit_en_d = dark ? '1 : ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            wrap_q       <= 1'b0;
            display_q    <= 7'b1111111;
            digit_en_q   <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            // Delayed so the pulse coincides with digit 0 appearing on the outputs.
            wrap_q       <= wrap;
            display_q    <= display_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= wrap_q;
        end
    end

    assign bus.display    = display_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/hex_display_mux.md
# hex_display_mux

Time-multiplexed driver for a bank of common-anode seven-segment digits, generalising the single-digit hex decoder to `DIGITS` digits behind one shared segment bus. It holds a `4*DIGITS`-bit hex value and scans one digit at a time at a programmable refresh rate. Per-digit blanking is supported. New values are applied only at frame boundaries, so a digit never shows a mix of old and new data. It sits between the datapath (counters, registers under test) and the board's segment and anode pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled; legal minimum 2.
- `clock`  in  1: single system clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `value`  in  4*DIGITS: hex nibbles; nibble k, `value[4k+3:4k]`, drives digit k, with digit 0 the least significant.
- `load`  in  1: captures `value` into the pending register on the cycle it is high.
- `blank_mask`  in  DIGITS: bit k high forces digit k dark. Sampled live, not shadowed.
- `display`  out  [0:6]: segments a..g with `display[0]` = a. Active-low.
- `digit_en`  out  DIGITS: anode enables, active-low, at most one bit low at a time.
- `frame_done`  out  1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- **Refresh counter `cnt`**
  - Width `$clog2(REFRESH_DIV)`.
  - Counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and advances the digit index `idx`.
  - `idx` wraps DIGITS-1 -> 0. With DIGITS=1, `idx` stays 0 but the wrap event still occurs.
- **Shadowing**
  - `load` writes `pending` and sets `pend_v`.
  - On the wrap event (`cnt` terminal and `idx`=DIGITS-1), if `pend_v` is set, `active <= pending` and `pend_v` clears.
  - If `load` is high in the wrap cycle, `value` bypasses straight to `active` and `pend_v` stays clear.
  - Back-to-back loads before a wrap: the last one wins.
- **Decode** of `active[4*idx+3:4*idx]`, active-low a..g:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0001100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- **Blanking:** when digit `idx` is blanked, `display` = 1111111 and `digit_en` = all ones for that slot. The scan timing is unchanged.
- **Reset values:**
  - Outputs: `display` = 1111111, `digit_en` = all ones, `frame_done` = 0.
  - Internal state: `cnt`, `idx`, `active`, `pending` and `pend_v` all 0.
- **Reset mid-scan:** everything returns to the reset values immediately, and any pending load is discarded.

## Timing
- `display`, `digit_en` and `frame_done` are all registered.
- Outputs reflect the `idx`/`active` state of the previous cycle, i.e. one cycle of latency.
- First cycle after `resetn` rises: `cnt` increments from 0. At the next edge, `digit_en[0]` = 0 and `display` = glyph 0 (0000001).
- Each digit is enabled for exactly REFRESH_DIV cycles. A frame is DIGITS*REFRESH_DIV cycles.
- `frame_done` goes high for exactly one cycle, on the same edge that `digit_en` moves to digit 0.
- Load-to-visible latency:
  - Minimum 2 cycles (load in the wrap cycle).
  - Maximum DIGITS*REFRESH_DIV + 1 cycles.
- `blank_mask` change to visible effect: 1 cycle.

## Configuration
- **`LEADING_ZERO_SUPPRESS_EN` defined:**
  - Digit k (k ≥ 1) is additionally blanked when nibble k of `active` and every higher nibble are all zero.
  - Digit 0 is never suppressed; a value of 0 shows a single "0".
  - Suppression is computed from `active`, so it changes only at frame boundaries.
- **Undefined:** all unblanked digits are shown, including leading zeros.

## Test plan
Bench settings: DIGITS=4, REFRESH_DIV=4.
1. **Reset and first scan.** Hold `resetn` low, release, load 0x1234 at cycle 1.
   - During reset: `display` = 1111111, `digit_en` = 1111.
   - First frame shows 0000 (value not yet applied).
   - Second frame: `digit_en` 1110 / 1101 / 1011 / 0111 with glyphs 4 / 3 / 2 / 1, 4 cycles each.
   - `frame_done` pulses every 16 cycles.
2. **Tear-free update.** Load 0xABCD while digit 2 is active.
   - Digits 2 and 3 still show 2 and 1 for the rest of the frame.
   - Next frame shows d, C, b, A.
3. **Load in the wrap cycle.** Assert `load` with 0xFFFF exactly in the wrap cycle.
   - Digit 0 of the very next frame shows F (0111000).
   - `pend_v` remains clear.
4. **Blanking.** Set `blank_mask` = 0101 with value 0x9876.
   - Digit 0 and digit 2 slots: `digit_en` = 1111, `display` = 1111111.
   - Digits 1 and 3 show 7 and 9.
   - Each slot still lasts 4 cycles.
5. **Reset mid-operation.** Pulse `resetn` low for 1 cycle mid-frame with a pending load of 0x5555.
   - Outputs return to reset values asynchronously.
   - The following frame shows 0000, not 5555.
6. **Leading-zero suppression.** With `LEADING_ZERO_SUPPRESS_EN` defined:
   - Value 0x0070 shows only digits 0 and 1 (glyphs 0 and 7); digits 2 and 3 are dark.
   - Value 0x0000 shows only digit 0 = 0.
   - Without the macro, all four digits are lit.
